puf_array_ctrl: RTL

Parametrised successor of the four-instance PUF wrapper. It owns the serial challenge register and drives a configurable number of PUF channels. A sequencer FSM arms the selected channel, lets it evaluate for a programmed window, and samples its response bit; optionally it repeats the evaluation and majority-votes the result. It sits between the scan-style pad interface and the analog/ring PUF instances, which remain external.

---
 rtl/puf_array_pkg.sv | 23 ++
 rtl/puf_array_if.sv | 28 ++
 rtl/puf_chal_sreg.sv | 24 ++
 rtl/puf_array_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/puf_array_pkg.sv
// puf_array_pkg: shared types and constants for the PUF array controller.
// Holds the sequencer state enum, synchroniser depth and a latency helper.
package puf_array_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        EVAL,
        SYNC,
        SAMPLE,
        DONE
    } puf_state_e;

    localparam int SYNC_STAGES = 2;

    // Cycles from the start request cycle to the done pulse, one evaluation.
    function automatic int puf_latency(input int arm_cyc, input int eval_cyc);
        int e;
        e = (eval_cyc < 1) ? 1 : eval_cyc;
        return 1 + arm_cyc + e + SYNC_STAGES + 2;
    endfunction

endpackage

// File: rtl/puf_array_if.sv
// puf_array_if: request/response bundle between the pad logic and the controller.
// master drives start/puf_sel/length/eval_cyc; slave returns busy/done/resp/length_o.
interface puf_array_if #(
    parameter int N_PUF  = 4,
    parameter int EVAL_W = 8
);
    localparam int SEL_W = $clog2(N_PUF);

    logic              start;
    logic [SEL_W-1:0]  puf_sel;
    logic [1:0]        length;
    logic [EVAL_W-1:0] eval_cyc;
    logic              busy;
    logic              done;
    logic              resp;
    logic [1:0]        length_o;

    modport master (
        output start, puf_sel, length, eval_cyc,
        input  busy, done, resp, length_o
    );

    modport slave (
        input  start, puf_sel, length, eval_cyc,
        output busy, done, resp, length_o
    );

endinterface

// File: rtl/puf_chal_sreg.sv
// puf_chal_sreg: challenge shift register, MSB-first serial out.
// Ports: clk, reset (sync, active-high), en, si in; so, q out.
module puf_chal_sreg #(
    parameter int CHAL_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              si,
    output logic              so,
    output logic [CHAL_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= {q[CHAL_W-2:0], si};
        end
    end

    assign so = q[CHAL_W-1];

endmodule

// File: rtl/puf_array_ctrl.sv
// puf_array_ctrl: challenge register plus arm/eval/sync/sample sequencer for N_PUF channels.
// Ports: clk, reset (sync, active-high); si/shift_en/so challenge scan; challenge,
// puf_reset, puf_out to the channels; bus (slave) carries start/puf_sel/length/eval_cyc
// in and busy/done/resp/length_o out. Define PUF_VOTE_EN for VOTES-way majority voting.
module puf_array_ctrl
    import puf_array_pkg::*;
#(
    parameter int N_PUF   = 4,
    parameter int CHAL_W  = 128,
    parameter int ARM_CYC = 4,
    parameter int EVAL_W  = 8,
    parameter int VOTES   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              si,
    input  logic              shift_en,
    output logic              so,
    output logic [CHAL_W-1:0] challenge,
    output logic [N_PUF-1:0]  puf_reset,
    input  logic [N_PUF-1:0]  puf_out,
    puf_array_if.slave        bus
);

    localparam int SEL_W = $clog2(N_PUF);
    localparam int ARM_W = $clog2(ARM_CYC + 1);
    localparam int CNT_W = (ARM_W > EVAL_W) ? ARM_W : EVAL_W;

    puf_state_e             state;
    puf_state_e             state_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [SEL_W-1:0]       sel_q;
    logic [EVAL_W-1:0]      eval_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [N_PUF-1:0]       sel_oh;
    logic                   idle;
    logic                   accept;
    logic                   released;
    logic                   puf_bit;
    logic                   sample_bit;
    logic                   last_vote;
    logic                   vote_res;

    assign idle   = (state == IDLE);
    assign accept = idle & bus.start;

    puf_chal_sreg #(.CHAL_W(CHAL_W)) u_sreg (
        .clk   (clk),
        .reset (reset),
        .en    (idle & shift_en),
        .si    (si),
        .so    (so),
        .q     (challenge)
    );

    // An out-of-range select decodes to all zeros: nothing released, bit reads 0.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_PUF; i++) begin
            sel_oh[i] = (sel_q == SEL_W'(i));
        end
    end

    assign released   = (state == EVAL) | (state == SYNC);
    assign puf_reset  = ~(sel_oh & {N_PUF{released}});
    assign puf_bit    = |(puf_out & sel_oh);
    assign sample_bit = sync_q[SYNC_STAGES-1];

`ifdef PUF_VOTE_EN
    localparam int VC_W = $clog2(VOTES + 1);

    logic [VC_W-1:0] vcnt;
    logic [VC_W-1:0] ones;
    logic [VC_W-1:0] ones_n;

    assign ones_n    = ones + VC_W'(sample_bit);
    assign last_vote = (vcnt == VC_W'(VOTES - 1));
    assign vote_res  = (ones_n > VC_W'(VOTES / 2));

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            vcnt <= '0;
            ones <= '0;
        end else if (state == SAMPLE) begin
            vcnt <= vcnt + VC_W'(1);
            ones <= ones_n;
        end
    end
`else
    assign last_vote = 1'b1;
    assign vote_res  = sample_bit;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ARM;
                    cnt_n   = CNT_W'(ARM_CYC - 1);
                end
            end
            ARM: begin
                if (cnt == '0) begin
                    state_n = EVAL;
                    cnt_n   = CNT_W'(eval_q) - CNT_W'(1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            EVAL: begin
                if (cnt == '0) begin
                    state_n = SYNC;
                    cnt_n   = CNT_W'(SYNC_STAGES - 1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SYNC: begin
                if (cnt == '0) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (last_vote) begin
                    state_n = DONE;
                end else begin
                    state_n = ARM;
                    cnt_n   = CNT_W'(ARM_CYC - 1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            sel_q        <= '0;
            eval_q       <= '0;
            sync_q       <= '0;
            bus.length_o <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.resp     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], puf_bit};
            bus.done <= 1'b0;
            if (accept) begin
                sel_q        <= bus.puf_sel;
                eval_q       <= (bus.eval_cyc == '0) ? EVAL_W'(1) : bus.eval_cyc;
                bus.length_o <= bus.length;
                bus.busy     <= 1'b1;
            end
            if (state == SAMPLE && last_vote) begin
                bus.done <= 1'b1;
                bus.resp <= vote_res;
            end
            if (state == DONE) begin
                bus.busy <= 1'b0;
            end
        end
    end

endmodule
